// File: rtl/mem_bus_pkg.sv
// Shared definitions for the RAM request bus: default widths, test-master FSM
// states and the write-pattern function used by the initiator and its models.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } test_state_e;

  // Callers truncate the result to their own data width.
  function automatic logic [31:0] pattern(input logic [31:0] addr,
                                          input logic [31:0] offset);
    return addr + offset;
  endfunction

endpackage

// File: rtl/ram_req_timer.sv
// Request wait counter: counts stalled cycles of an outstanding request and
// flags expiry on the cycle that would bring the count to TIMEOUT.
module ram_req_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int NEED_W = $clog2(TIMEOUT + 1);
  localparam int CW     = (NEED_W > 8) ? NEED_W : 8;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  // Fires on the TIMEOUT-th stalled edge so the abort lands exactly then.
  assign expire = en && !clr && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_test_initiator.sv
// Memory self-test master: writes addr+PAT_OFFSET to every word, reads all back
// and compares, reporting pass/fail, failure count and first failing address.
module ram_test_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = 2048,
  parameter int PAT_OFFSET = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              write,
  output logic              valid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  input  logic              error,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       fail_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              timeout
);

  test_state_e       state, state_n;
  logic [ADDR_W-1:0] addr_n, ffa_n;
  logic [DATA_W-1:0] wdata_n, exp_rd, wd_first, wd_next;
  logic              write_n, valid_n, busy_n, done_n, pass_n, timeout_n;
  logic [15:0]       fc_n;

  logic xfer, start_ok, last, bad, tmr_exp;

  assign xfer     = valid && ready;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign last     = (addr == ADDR_W'(DEPTH - 1));
  assign exp_rd   = DATA_W'(pattern(32'(addr), 32'(PAT_OFFSET)));
  assign wd_first = DATA_W'(pattern(32'd0, 32'(PAT_OFFSET)));
  assign wd_next  = DATA_W'(pattern(32'(addr) + 32'd1, 32'(PAT_OFFSET)));
  // Mismatch and error on the same read still count as one failure.
  assign bad      = xfer && (error || (state == READ && rdata != exp_rd));

  ram_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (xfer || start_ok),
    .en     (valid && !ready),
    .expire (tmr_exp)
  );

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    wdata_n   = wdata;
    write_n   = write;
    valid_n   = valid;
    busy_n    = busy;
    done_n    = done;
    pass_n    = pass;
    fc_n      = fail_count;
    ffa_n     = first_fail_addr;
    timeout_n = timeout;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_n   = WRITE;
          addr_n    = '0;
          wdata_n   = wd_first;
          write_n   = 1'b1;
          valid_n   = 1'b1;
          busy_n    = 1'b1;
          done_n    = 1'b0;
          pass_n    = 1'b0;
          fc_n      = '0;
          ffa_n     = '0;
          timeout_n = 1'b0;
        end
      end
      WRITE, READ: begin
        if (tmr_exp) begin
          timeout_n = 1'b1;
          if (fail_count == 16'd0) ffa_n = addr;
          state_n = DONE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = 1'b0;
        end else if (xfer) begin
          if (bad) begin
            if (fail_count != 16'hFFFF) fc_n = fail_count + 16'd1;
            if (fail_count == 16'd0)    ffa_n = addr;
          end
          if (state == WRITE) begin
            if (last) begin
              state_n = READ;
              addr_n  = '0;
              write_n = 1'b0;
              wdata_n = wd_first;
            end else begin
              addr_n  = addr + ADDR_W'(1);
              wdata_n = wd_next;
            end
          end else begin
            if (last) begin
              state_n = DONE;
              valid_n = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              pass_n  = (fc_n == 16'd0) && !timeout;
            end else begin
              addr_n = addr + ADDR_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      addr            <= '0;
      wdata           <= '0;
      write           <= 1'b0;
      valid           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      timeout         <= 1'b0;
    end else begin
      state           <= state_n;
      addr            <= addr_n;
      wdata           <= wdata_n;
      write           <= write_n;
      valid           <= valid_n;
      busy            <= busy_n;
      done            <= done_n;
      pass            <= pass_n;
      fail_count      <= fc_n;
      first_fail_addr <= ffa_n;
      timeout         <= timeout_n;
    end
  end

endmodule

// File: tb/tb_ram_test_initiator.sv
// Scoreboard bench: a RAM responder model with configurable waits and faults,
// expected transfers/status built from the test rules, checked by a monitor.
module tb_ram_test_initiator;
  localparam int AW = 16, DW = 16, DEPTH = 256, TO = 255, OFS = 1;

  logic clk = 0, rst = 0, start = 0;
  logic [AW-1:0] addr, first_fail_addr;
  logic [DW-1:0] wdata, rdata;
  logic write, valid, ready, error, busy, done, pass, timeout;
  logic [15:0] fail_count;

  always #5 clk = ~clk;

  ram_test_initiator #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
                       .PAT_OFFSET(OFS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
    .write(write), .valid(valid), .rdata(rdata), .ready(ready), .error(error),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_addr(first_fail_addr), .timeout(timeout));

  typedef struct {bit wr; int a; int d;} xfer_t;
  typedef struct {bit pass; int fc; int ffa; bit to;} st_t;
  xfer_t exp_q[$], obs_q[$];
  st_t   exp_st[$];

  int n_chk = 0, n_fail = 0;
  bit corrupt[DEPTH], werr[DEPTH], rerr[DEPTH];
  int hang_addr = -1, fix_w = 0, max_w = 0;
  logic [DW-1:0] mem[DEPTH];
  int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, stall_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the full transfer list and final status implied by the faults.
  task automatic build_expected();
    int fc = 0, ffa = -1, nw;
    bit to = 0;
    nw = (hang_addr >= 0) ? hang_addr : DEPTH;
    for (int a = 0; a < nw; a++) begin
      exp_q.push_back('{1'b1, a, (a + OFS) % 65536});
      if (werr[a]) begin fc++; if (ffa < 0) ffa = a; end
    end
    if (hang_addr >= 0) begin
      to = 1;
      if (ffa < 0) ffa = hang_addr;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        exp_q.push_back('{1'b0, a, 0});
        if (corrupt[a] || rerr[a]) begin fc++; if (ffa < 0) ffa = a; end
      end
    end
    exp_st.push_back('{(fc == 0) && !to, fc, (ffa < 0) ? 0 : ffa, to});
  endtask

  // Responder: decides ready at the falling edge; transfer completes at the next rise.
  initial begin
    int cur_w, waited, a;
    bit need_new, have_prev;
    logic [AW-1:0] h_addr; logic [DW-1:0] h_wdata; logic h_write;
    ready = 0; rdata = 0; error = 0; need_new = 1; have_prev = 0; cur_w = 0; waited = 0;
    forever begin
      @(negedge clk);
      ready = 0; error = 0; rdata = DW'($urandom);
      if (rst || !valid) begin
        need_new = 1; have_prev = 0;
      end else begin
        if (have_prev) begin
          chk("stable_addr", addr, h_addr);
          chk("stable_wdata", wdata, h_wdata);
          chk("stable_write", write, h_write);
        end
        if (need_new) begin
          cur_w = (fix_w >= 0) ? fix_w : $urandom_range(0, max_w);
          waited = 0; need_new = 0;
        end
        a = int'(addr);
        if ((write && a == hang_addr) || waited < cur_w) begin
          if (write && a == hang_addr) stall_cnt++;
          else waited++;
          h_addr = addr; h_wdata = wdata; h_write = write; have_prev = 1;
        end else begin
          ready = 1;
          if (a < DEPTH) begin
            if (write) begin mem[a] = wdata; error = werr[a]; end
            else begin rdata = mem[a] ^ (corrupt[a] ? 16'h0001 : 16'h0000); error = rerr[a]; end
          end
          obs_q.push_back('{write, a, int'(wdata)});
          need_new = 1; have_prev = 0;
        end
      end
    end
  end

  // Monitor: compares completed transfers and the status presented at done.
  initial begin
    xfer_t o, e;
    st_t s;
    bit done_q = 0;
    forever begin
      @(posedge clk); #1;
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) chk("xfer_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("xfer_write", o.wr, e.wr);
          chk("xfer_addr", o.a, e.a);
          if (e.wr) chk("xfer_wdata", o.d, e.d);
        end
      end
      if (done && !done_q) begin
        done_cyc = cyc;
        if (exp_st.size() == 0) chk("status_unexpected", 1, 0);
        else begin
          s = exp_st.pop_front();
          chk("pass", pass, s.pass);
          chk("fail_count", fail_count, s.fc);
          chk("first_fail_addr", first_fail_addr, s.ffa);
          chk("timeout", timeout, s.to);
          chk("valid_at_done", valid, 0);
          chk("busy_at_done", busy, 0);
          chk("missing_xfers", exp_q.size(), 0);
          exp_q.delete();
        end
        done_cnt++;
      end
      done_q = done;
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < DEPTH; i++) begin
      corrupt[i] = 0; werr[i] = 0; rerr[i] = 0; mem[i] = DW'($urandom);
    end
    hang_addr = -1; fix_w = 0; max_w = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1; start_cyc = cyc;
    @(negedge clk); start = 0;
  endtask

  task automatic run_test(input int mid_start);
    int dc;
    build_expected();
    dc = done_cnt;
    pulse_start();
    for (int i = 0; i < 20000 && done_cnt == dc; i++) begin
      @(negedge clk);
      start = (i == mid_start);
    end
    start = 0;
    if (done_cnt == dc) begin
      chk("done_reached", 0, 1);
      exp_q.delete(); exp_st.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail_count"}, fail_count, 0);
    chk({tag, "_ffa"}, first_fail_addr, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_write"}, write, 0);
  endtask

  initial begin
    int n;
    bit hit;
    #1 rst = 1;
    #2 check_reset_outputs("reset");
    @(negedge clk) rst = 0;
    repeat (2) @(negedge clk);

    clear_cfg();                       // zero-wait clean pass
    run_test(-1);
    chk("latency_min", (done_cyc - start_cyc) >= 2 * DEPTH + 1, 1);

    clear_cfg();                       // corrupted reads at 100 and 200
    corrupt[100] = 1; corrupt[200] = 1;
    run_test(-1);

    clear_cfg();                       // three wait cycles on every transfer
    fix_w = 3;
    run_test(-1);

    clear_cfg();                       // write to addr 5 never acknowledged
    hang_addr = 5; stall_cnt = 0;
    run_test(-1);
    chk("stall_cycles", stall_cnt, TO);
    hang_addr = -1;

    clear_cfg();                       // read error at 7, start while busy
    rerr[7] = 1;
    run_test(100);

    clear_cfg();                       // reset in the middle of the read pass
    build_expected();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(posedge clk); #3;
      hit = valid && !write && (addr == 16'd50);
    end
    chk("reached_read50", hit, 1);
    rst = 1;
    #1 check_reset_outputs("midreset");
    exp_q.delete(); exp_st.delete(); obs_q.delete();
    @(negedge clk) rst = 0;
    @(negedge clk);
    clear_cfg();
    run_test(-1);

    for (int r = 0; r < 3; r++) begin  // random waits and fault sets
      clear_cfg();
      fix_w = -1; max_w = $urandom_range(0, 2);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) corrupt[$urandom_range(0, DEPTH - 1)] = 1;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) werr[$urandom_range(0, DEPTH - 1)] = 1;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) rerr[$urandom_range(0, DEPTH - 1)] = 1;
      run_test(-1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
